// File: rtl/seq_pkg.sv
// Shared types and entry layout for the note sequencer and its FIFO.
// A note entry packs {tone, vol, dur} into 18 bits.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int TONE_W  = 6;
  localparam int VOL_W   = 4;
  localparam int DUR_W   = 8;
  localparam int ENTRY_W = TONE_W + VOL_W + DUR_W;

  localparam int TONE_LSB = 12;
  localparam int VOL_LSB  = 8;
  localparam int DUR_LSB  = 0;

  localparam logic [TONE_W-1:0] REST_CODE = 6'd0;
  localparam int TONE_MAX_DEFAULT = 48;

  // Codes outside 1..tone_max are treated as silent rests.
  function automatic logic is_rest(input logic [TONE_W-1:0] tone, input int tone_max);
    return (tone == REST_CODE) || (int'(tone) > tone_max);
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO for note entries; extra pointer MSB separates full from empty.
// The head entry is presented combinationally so the sequencer can act on it in LOAD.
module note_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      used;
  logic             wr_ok;
  logic             rd_ok;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign last    = (used == PTR_ONE);
  // Full is judged before any same-cycle pop, so a write into a full FIFO is dropped.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays buffered note entries in order: LOAD pops a note, PLAY drives the tone
// generator for dur*TICK_CYCLES cycles, GAP inserts GAP_CYCLES of silence.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int DEPTH       = 16,
  parameter int TONE_MAX    = TONE_MAX_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WR_EN,
  input  logic [17:0] WR_DATA,
  output logic        FULL,
  input  logic        START,
  input  logic        STOP,
  output logic        BUSY,
  output logic        DONE,
  output logic [5:0]  TONE,
  output logic [3:0]  VOL,
  output logic        EN
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DUR_W-1:0]    unit_q, unit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ENTRY_W-1:0]  head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_last;
  logic                pop;
  logic                wr_accept;
  logic [TONE_W-1:0]   head_tone;
  logic [VOL_W-1:0]    head_vol;
  logic [DUR_W-1:0]    head_dur;
  logic                head_rest;

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (WR_EN),
    .wr_data (WR_DATA),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .last    (fifo_last)
  );

  assign wr_accept = WR_EN && !fifo_full;
  assign head_tone = head[TONE_LSB +: TONE_W];
  assign head_vol  = head[VOL_LSB +: VOL_W];
  assign head_dur  = head[DUR_LSB +: DUR_W];
  assign head_rest = is_rest(head_tone, TONE_MAX);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    gap_d   = gap_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    vol_d   = vol_q;
    en_d    = en_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && !STOP && !fifo_empty) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        pop    = 1'b1;
        tick_d = '0;
        unit_d = '0;
        gap_d  = '0;
        if (head_dur == '0) begin
          // Zero-duration entries are skipped; a write landing now keeps us going.
          if (fifo_last && !wr_accept) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_PLAY;
          dur_d   = head_dur;
          tone_d  = head_rest ? REST_CODE : head_tone;
          vol_d   = head_vol;
          en_d    = !head_rest;
        end
      end

      ST_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (unit_q == dur_q - DUR_W'(1)) begin
            state_d = ST_GAP;
            unit_d  = '0;
            en_d    = 1'b0;
          end else begin
            unit_d = unit_q + DUR_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (fifo_empty) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort drops the current note but leaves queued entries for a later START.
    if (STOP && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      tick_d  = '0;
      unit_d  = '0;
      gap_d   = '0;
      done_d  = 1'b0;
      pop     = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      unit_q  <= '0;
      gap_q   <= '0;
      dur_q   <= '0;
      tone_q  <= '0;
      vol_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      gap_q   <= gap_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      vol_q   <= vol_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign FULL = fifo_full;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign TONE = tone_q;
  assign VOL  = vol_q;
  assign EN   = en_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench: directed table, STOP/reset sequences and random note lists
// compared cycle by cycle against a timeline model built from the note list.
module tb_note_sequencer;

  localparam int TICK  = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;
  localparam int TMAX  = 48;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WR_EN = 1'b0;
  logic [17:0] WR_DATA = '0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        FULL, BUSY, DONE, EN;
  logic [5:0]  TONE;
  logic [3:0]  VOL;

  note_sequencer #(
    .TICK_CYCLES (TICK),
    .GAP_CYCLES  (GAP),
    .DEPTH       (DEPTH),
    .TONE_MAX    (TMAX)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .START   (START),
    .STOP    (STOP),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .TONE    (TONE),
    .VOL     (VOL),
    .EN      (EN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en;
    logic       tv;
    logic [5:0] tone;
    logic [3:0] vol;
  } exp_t;

  typedef struct {
    int               n;
    logic [5:0][17:0] ent;
    logic             full;
    int               en_cyc;
    int               busy_cyc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [17:0] play_q[$];
  exp_t        exp_q[$];
  int last_en, last_busy, last_done;
  vec_t tbl[6];

  function automatic logic [17:0] mk(input int t, input int v, input int d);
    logic [5:0] tt; logic [3:0] vv; logic [7:0] dd;
    tt = t[5:0]; vv = v[3:0]; dd = d[7:0];
    return {tt, vv, dd};
  endfunction

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic check(input logic ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Timeline per note: one LOAD cycle, then dur*TICK sounding cycles and GAP silent
  // cycles unless dur is zero; after the last note one DONE cycle, then quiet idle.
  task automatic build_model();
    exp_t x;
    logic [5:0] t; logic [3:0] v; int d; logic rest;
    exp_q.delete();
    foreach (play_q[i]) begin
      t = play_q[i][17:12]; v = play_q[i][11:8]; d = int'(play_q[i][7:0]);
      rest = (t == 6'd0) || (int'(t) > TMAX);
      x = '{busy:1'b1, done:1'b0, en:1'b0, tv:1'b0, tone:6'd0, vol:4'd0};
      exp_q.push_back(x);
      if (d != 0) begin
        for (int c = 0; c < d * TICK; c++) begin
          x = '{busy:1'b1, done:1'b0, en:!rest, tv:1'b1, tone:(rest ? 6'd0 : t), vol:v};
          exp_q.push_back(x);
        end
        for (int c = 0; c < GAP; c++) begin
          x = '{busy:1'b1, done:1'b0, en:1'b0, tv:1'b1, tone:(rest ? 6'd0 : t), vol:v};
          exp_q.push_back(x);
        end
      end
    end
    x = '{busy:1'b0, done:1'b1, en:1'b0, tv:1'b0, tone:6'd0, vol:4'd0};
    exp_q.push_back(x);
    x = '{busy:1'b0, done:1'b0, en:1'b0, tv:1'b0, tone:6'd0, vol:4'd0};
    exp_q.push_back(x);
  endtask

  task automatic write_entries(input string tag, input int n, input logic [5:0][17:0] ent);
    play_q.delete();
    for (int i = 0; i < n; i++) begin
      WR_EN = 1'b1;
      WR_DATA = ent[i];
      if (play_q.size() < DEPTH) play_q.push_back(ent[i]);
      step();
    end
    WR_EN = 1'b0;
    check(FULL == (play_q.size() == DEPTH), {tag, " full"},
          $sformatf("got FULL=%b, want %b", FULL, play_q.size() == DEPTH));
  endtask

  task automatic run_trace(input string tag);
    exp_t x;
    logic ok;
    int en_n, busy_n, done_n;
    en_n = 0; busy_n = 0; done_n = 0;
    build_model();
    START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) step();
      x = exp_q[k];
      ok = (BUSY == x.busy) && (DONE == x.done) && (EN == x.en) &&
           (!x.tv || (TONE == x.tone && VOL == x.vol));
      check(ok, $sformatf("%s cyc%0d", tag, k),
            $sformatf("got busy=%b done=%b en=%b tone=%0d vol=%0d, want busy=%b done=%b en=%b tone=%0d vol=%0d",
                      BUSY, DONE, EN, TONE, VOL, x.busy, x.done, x.en, x.tone, x.vol));
      en_n += int'(EN);
      busy_n += int'(BUSY);
      done_n += int'(DONE);
    end
    last_en = en_n; last_busy = busy_n; last_done = done_n;
    $display("%s: notes=%0d cycles=%0d en=%0d busy=%0d done=%0d",
             tag, play_q.size(), exp_q.size(), en_n, busy_n, done_n);
  endtask

  initial begin
    logic [5:0][17:0] ent;
    int n;

    tbl[0] = '{n:1, ent:{18'd0, 18'd0, 18'd0, 18'd0, 18'd0, mk(10, 8, 3)},
               full:1'b0, en_cyc:12, busy_cyc:15};
    tbl[1] = '{n:3, ent:{18'd0, 18'd0, 18'd0, mk(7, 5, 1), mk(6, 4, 2), mk(48, 3, 1)},
               full:1'b0, en_cyc:16, busy_cyc:25};
    tbl[2] = '{n:2, ent:{18'd0, 18'd0, 18'd0, 18'd0, mk(50, 9, 1), mk(0, 2, 1)},
               full:1'b0, en_cyc:0, busy_cyc:14};
    tbl[3] = '{n:2, ent:{18'd0, 18'd0, 18'd0, 18'd0, mk(21, 2, 1), mk(20, 1, 0)},
               full:1'b0, en_cyc:4, busy_cyc:8};
    tbl[4] = '{n:1, ent:{18'd0, 18'd0, 18'd0, 18'd0, 18'd0, mk(20, 1, 0)},
               full:1'b0, en_cyc:0, busy_cyc:1};
    tbl[5] = '{n:5, ent:{18'd0, mk(5, 15, 1), mk(4, 15, 1), mk(3, 15, 1), mk(2, 15, 1), mk(1, 15, 1)},
               full:1'b1, en_cyc:16, busy_cyc:28};

    // Reset state
    #12;
    check({TONE, VOL, EN, FULL, BUSY, DONE} == 14'd0, "reset state",
          $sformatf("got tone=%0d vol=%0d en=%b full=%b busy=%b done=%b, want all 0",
                    TONE, VOL, EN, FULL, BUSY, DONE));
    @(posedge CLK); #1;
    RST_N = 1'b1;
    step();

    for (int r = 0; r < 6; r++) begin
      write_entries($sformatf("tbl%0d", r), tbl[r].n, tbl[r].ent);
      check(FULL == tbl[r].full, $sformatf("tbl%0d full const", r),
            $sformatf("got FULL=%b, want %b", FULL, tbl[r].full));
      run_trace($sformatf("tbl%0d", r));
      check(last_en == tbl[r].en_cyc, $sformatf("tbl%0d en cycles", r),
            $sformatf("got %0d, want %0d", last_en, tbl[r].en_cyc));
      check(last_busy == tbl[r].busy_cyc, $sformatf("tbl%0d busy cycles", r),
            $sformatf("got %0d, want %0d", last_busy, tbl[r].busy_cyc));
      check(last_done == 1, $sformatf("tbl%0d done pulses", r),
            $sformatf("got %0d, want 1", last_done));
    end

    // STOP two cycles into the first note's PLAY
    ent = '0;
    ent[0] = mk(11, 4, 1);
    ent[1] = mk(12, 5, 2);
    write_entries("stop", 2, ent);
    START = 1'b1; step(); START = 1'b0;
    step(); step();
    check(EN == 1'b1 && TONE == 6'd11, "stop pre-play",
          $sformatf("got en=%b tone=%0d, want en=1 tone=11", EN, TONE));
    STOP = 1'b1; step(); STOP = 1'b0;
    check(EN == 1'b0 && BUSY == 1'b0 && DONE == 1'b0, "stop response",
          $sformatf("got en=%b busy=%b done=%b, want 0 0 0", EN, BUSY, DONE));
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n += int'(DONE) + int'(BUSY) + int'(EN);
    end
    check(n == 0, "stop quiet", $sformatf("got %0d active samples, want 0", n));
    play_q.delete();
    play_q.push_back(mk(12, 5, 2));
    run_trace("resume");

    // Random note lists
    for (int it = 0; it < 15; it++) begin
      n = int'($urandom_range(1, 6));
      ent = '0;
      for (int i = 0; i < n; i++)
        ent[i] = mk(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)));
      write_entries($sformatf("rnd%0d", it), n, ent);
      run_trace($sformatf("rnd%0d", it));
    end

    // Asynchronous reset in the middle of a note
    ent = '0;
    ent[0] = mk(33, 7, 2);
    ent[1] = mk(34, 6, 1);
    write_entries("arst", 2, ent);
    START = 1'b1; step(); START = 1'b0;
    step(); step();
    check(EN == 1'b1 && TONE == 6'd33 && VOL == 4'd7, "arst pre-play",
          $sformatf("got en=%b tone=%0d vol=%0d, want 1 33 7", EN, TONE, VOL));
    #2;
    RST_N = 1'b0;
    #1;
    check(EN == 1'b0 && TONE == 6'd0 && VOL == 4'd0 && BUSY == 1'b0 && FULL == 1'b0,
          "arst async clear",
          $sformatf("got en=%b tone=%0d vol=%0d busy=%b full=%b, want all 0",
                    EN, TONE, VOL, BUSY, FULL));
    step();
    RST_N = 1'b1;
    step();
    START = 1'b1; step(); START = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(BUSY) + int'(EN) + int'(DONE);
      step();
    end
    check(n == 0, "arst empty start", $sformatf("got %0d active samples, want 0", n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
